// File: rtl/spi_flash_sched.sv
// Two-requester SPI flash command scheduler: round-robin grant, opcode + up to three
// response bytes through an external byte engine, watchdog abort and an inter-command gap.
module spi_flash_sched #(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [7:0]  opcode0,
  input  logic [7:0]  opcode1,
  input  logic [1:0]  rd_len0,
  input  logic [1:0]  rd_len1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic        err,
  output logic [23:0] rd_data,
  output logic        busy,
  output logic        chip_select,
  output logic        byte_start,
  output logic [7:0]  tx_byte,
  input  logic        byte_done,
  input  logic [7:0]  rx_byte
);

  localparam int unsigned WdW  = $clog2(TIMEOUT + 1);
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StCsSetup, StSendOp, StWaitOp, StSendRx, StWaitRx, StCsHold, StGap
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic            err_q, err_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic [7:0]      op_q, op_d;
  logic [1:0]      len_q, len_d;
  logic [1:0]      rem_q, rem_d;
  logic [23:0]     acc_q, acc_d;
  logic [23:0]     rd_data_q, rd_data_d;
  logic [WdW-1:0]  wd_q, wd_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            win;

  // On a tie the requester that was not served last wins.
  assign win = (req == 2'b11) ? ~last_q : req[1];

  always_comb begin
    state_d   = state_q;
    gnt_d     = '0;
    err_d     = 1'b0;
    owner_d   = owner_q;
    last_d    = last_q;
    op_d      = op_q;
    len_d     = len_q;
    rem_d     = rem_q;
    acc_d     = acc_q;
    rd_data_d = rd_data_q;
    wd_d      = wd_q;
    gap_d     = '0;
    case (state_q)
      StIdle: begin
        if (req != 2'b00) begin
          gnt_d   = win ? 2'b10 : 2'b01;
          owner_d = win;
          last_d  = win;
          op_d    = win ? opcode1 : opcode0;
          len_d   = win ? rd_len1 : rd_len0;
          acc_d   = '0;
          state_d = StCsSetup;
        end
      end
      StCsSetup: state_d = StSendOp;
      StSendOp: begin
        // Counts cycles since byte_start, so the byte_start cycle itself is cycle 1.
        wd_d    = WdW'(1);
        state_d = StWaitOp;
      end
      StWaitOp: begin
        if (byte_done) begin
          if (len_q == 2'd0) begin
            state_d = StCsHold;
          end else begin
            rem_d   = len_q;
            state_d = StSendRx;
          end
        end else if (wd_q == WdLast) begin
          err_d   = 1'b1;
          state_d = StGap;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StSendRx: begin
        wd_d    = WdW'(1);
        state_d = StWaitRx;
      end
      StWaitRx: begin
        if (byte_done) begin
          acc_d   = {acc_q[15:0], rx_byte};
          rem_d   = rem_q - 2'd1;
          state_d = (rem_q == 2'd1) ? StCsHold : StSendRx;
        end else if (wd_q == WdLast) begin
          err_d   = 1'b1;
          state_d = StGap;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StCsHold: begin
        // A zero-length read leaves the previous response visible.
        if (len_q != 2'd0) rd_data_d = acc_q;
        state_d = StGap;
      end
      StGap: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GapLast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      err_q     <= 1'b0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      op_q      <= '0;
      len_q     <= '0;
      rem_q     <= '0;
      acc_q     <= '0;
      rd_data_q <= '0;
      wd_q      <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      err_q     <= err_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      op_q      <= op_d;
      len_q     <= len_d;
      rem_q     <= rem_d;
      acc_q     <= acc_d;
      rd_data_q <= rd_data_d;
      wd_q      <= wd_d;
      gap_q     <= gap_d;
    end
  end

  assign gnt         = gnt_q;
  assign err         = err_q;
  assign rd_data     = rd_data_q;
  assign busy        = (state_q != StIdle);
  assign chip_select = !(state_q inside {StCsSetup, StSendOp, StWaitOp, StSendRx, StWaitRx});
  assign byte_start  = (state_q == StSendOp) || (state_q == StSendRx);
  assign tx_byte     = (state_q == StSendOp) ? op_q : 8'h00;
  assign done        = (state_q == StCsHold) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_spi_flash_sched.sv
// Bench for spi_flash_sched: fixed vectors, randomized transactions against a
// transaction-level model, and hand sequences for timeout, reset and spurious byte_done.
module tb_spi_flash_sched;

  localparam int unsigned Gap = 2;
  localparam int unsigned To  = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [7:0]  opcode0, opcode1;
  logic [1:0]  rd_len0, rd_len1;
  logic [1:0]  gnt, done;
  logic        err, busy, chip_select, byte_start, byte_done;
  logic [23:0] rd_data;
  logic [7:0]  tx_byte, rx_byte;

  // Byte engine model and manual byte_done injection.
  logic        eng_done, man_done, eng_mute;
  logic [7:0]  eng_rxb;
  logic [7:0]  eng_rx [3];
  int          eng_cnt, eng_idx, eng_lat;

  int          total = 0;
  int          bad   = 0;
  int          m_last;
  logic [23:0] m_rd;

  always #5 clk = ~clk;

  assign byte_done = eng_done | man_done;
  assign rx_byte   = eng_rxb;

  spi_flash_sched #(.GAP_CYCLES(Gap), .TIMEOUT(To)) dut (
    .clk(clk), .rst(rst), .req(req), .opcode0(opcode0), .opcode1(opcode1),
    .rd_len0(rd_len0), .rd_len1(rd_len1), .gnt(gnt), .done(done), .err(err),
    .rd_data(rd_data), .busy(busy), .chip_select(chip_select), .byte_start(byte_start),
    .tx_byte(tx_byte), .byte_done(byte_done), .rx_byte(rx_byte)
  );

  always @(negedge clk) begin
    if (rst) begin
      eng_done <= 1'b0;
      eng_cnt  <= 0;
      eng_idx  <= 0;
      eng_rxb  <= 8'h00;
    end else begin
      eng_done <= 1'b0;
      if (chip_select) eng_idx <= 0;
      if (byte_start && !eng_mute) begin
        eng_cnt <= eng_lat + 1;
      end else if (eng_cnt == 1) begin
        eng_done <= 1'b1;
        eng_rxb  <= (eng_idx > 0 && eng_idx <= 3) ? eng_rx[eng_idx-1] : 8'hE7;
        eng_idx  <= eng_idx + 1;
        eng_cnt  <= 0;
      end else if (eng_cnt > 1) begin
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input logic [1:0] rq, input logic hold, input logic spur,
                         input logic [7:0] o0, input logic [7:0] o1,
                         input logic [1:0] l0, input logic [1:0] l1,
                         input logic [23:0] rxb, input int lat,
                         input logic [1:0] egnt, input logic [23:0] erd,
                         input string tag, output int gwait);
    logic [7:0]  txq[$];
    logic [7:0]  eop;
    logic [1:0]  elen, got_gnt, got_done;
    logic        got_err, out;
    logic [23:0] rd_seen;
    int          csbad, proto, gcnt, gbs, gw;
    opcode0 = o0; opcode1 = o1; rd_len0 = l0; rd_len1 = l1;
    eng_lat = lat;
    eng_rx[0] = rxb[23:16]; eng_rx[1] = rxb[15:8]; eng_rx[2] = rxb[7:0];
    req = rq;
    got_gnt = 2'b00; gw = -1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (gnt != 2'b00) begin
        got_gnt = gnt; gw = k;
        break;
      end
    end
    gwait = gw;
    chk({tag, " gnt"}, got_gnt, egnt);
    if (!hold) req = 2'b00;
    // Inputs are only meaningful at grant; scramble them afterwards.
    opcode0 = 8'($urandom); opcode1 = 8'($urandom);
    rd_len0 = 2'($urandom); rd_len1 = 2'($urandom);
    csbad = 0; proto = 0; out = 1'b0; got_done = 2'b00; got_err = 1'b0;
    if (got_gnt != 2'b00) begin
      for (int k = 0; k < 200; k++) begin
        tick();
        if (byte_start) begin
          if (out || chip_select) proto++;
          out = 1'b1;
          txq.push_back(tx_byte);
        end else if (byte_done) begin
          out = 1'b0;
        end
        if (done != 2'b00 || err) begin
          got_done = done; got_err = err;
          break;
        end
        if (chip_select) csbad++;
      end
    end
    eop  = egnt[1] ? o1 : o0;
    elen = egnt[1] ? l1 : l0;
    chk({tag, " done"}, got_done, egnt);
    chk({tag, " err"}, got_err, 0);
    chk({tag, " byte_starts"}, txq.size(), 1 + elen);
    for (int i = 0; i < txq.size(); i++)
      chk($sformatf("%s tx%0d", tag, i), txq[i], (i == 0) ? eop : 8'h00);
    chk({tag, " cs low during xfer"}, csbad, 0);
    chk({tag, " byte protocol"}, proto, 0);
    gcnt = 0; gbs = 0; csbad = 0; rd_seen = '0;
    for (int k = 0; k < 50; k++) begin
      tick();
      man_done = spur && (k == 0);
      if (k == 0) rd_seen = rd_data;
      if (!busy) break;
      gcnt++;
      if (byte_start) gbs++;
      if (!chip_select) csbad++;
    end
    man_done = 1'b0;
    chk({tag, " rd_data"}, rd_seen, erd);
    chk({tag, " gap cycles"}, gcnt, Gap);
    chk({tag, " gap quiet"}, gbs + csbad, 0);
  endtask

  typedef struct {
    logic [1:0]  rq;
    logic [7:0]  o0, o1;
    logic [1:0]  l0, l1;
    logic [23:0] rx;
    int          lat;
    logic [1:0]  egnt;
    logic [23:0] erd;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int          gw, w, n, nbs, bad_ev;
    logic [1:0]  rq, len;
    logic [7:0]  o0, o1;
    logic [1:0]  l0, l1;
    logic [23:0] rx, erd;
    logic        seen_err, cs_at_err;

    tbl[0] = '{2'b01, 8'h9F, 8'h00, 2'd3, 2'd0, 24'h202015, 1, 2'b01, 24'h202015};
    tbl[1] = '{2'b10, 8'h00, 8'h05, 2'd2, 2'd0, 24'h000000, 0, 2'b10, 24'h202015};
    tbl[2] = '{2'b01, 8'h03, 8'h77, 2'd1, 2'd3, 24'hA50000, 2, 2'b01, 24'h0000A5};
    tbl[3] = '{2'b11, 8'h11, 8'h22, 2'd2, 2'd2, 24'h123400, 0, 2'b10, 24'h001234};
    tbl[4] = '{2'b11, 8'h0B, 8'h44, 2'd3, 2'd1, 24'hDEADBE, 3, 2'b01, 24'hDEADBE};
    tbl[5] = '{2'b10, 8'h55, 8'h9F, 2'd0, 2'd2, 24'hC33C00, 1, 2'b10, 24'h00C33C};

    rst = 1'b1; req = 2'b00; opcode0 = 8'h00; opcode1 = 8'h00; rd_len0 = 2'd0; rd_len1 = 2'd0;
    man_done = 1'b0; eng_mute = 1'b0; eng_lat = 0;
    eng_rx[0] = 8'h00; eng_rx[1] = 8'h00; eng_rx[2] = 8'h00;
    repeat (3) tick();
    chk("reset cs", chip_select, 1);
    chk("reset busy", busy, 0);
    chk("reset gnt/done/err", {gnt, done, err}, 0);
    chk("reset byte_start", byte_start, 0);
    chk("reset tx_byte", tx_byte, 0);
    chk("reset rd_data", rd_data, 0);
    rst = 1'b0;
    m_last = 1; m_rd = '0;

    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i].rq, 1'b0, i == 1, tbl[i].o0, tbl[i].o1, tbl[i].l0, tbl[i].l1,
              tbl[i].rx, tbl[i].lat, tbl[i].egnt, tbl[i].erd, $sformatf("vec%0d", i), gw);
      if (i == 0) chk("first grant latency", gw, 0);
      m_last = tbl[i].egnt[1] ? 1 : 0;
      m_rd   = tbl[i].erd;
    end

    for (int r = 0; r < 40; r++) begin
      rq = 2'($urandom_range(1, 3));
      o0 = 8'($urandom); o1 = 8'($urandom);
      l0 = 2'($urandom); l1 = 2'($urandom);
      rx = 24'($urandom);
      if (rq == 2'b11) w = (m_last == 1) ? 0 : 1;
      else             w = (rq == 2'b10) ? 1 : 0;
      len = (w == 1) ? l1 : l0;
      erd = m_rd;
      if (len != 0) begin
        erd = 0;
        for (int j = 0; j < len; j++) erd = erd * 256 + ((rx >> (16 - 8 * j)) & 24'hFF);
      end
      run_txn(rq, 1'b0, 1'($urandom), o0, o1, l0, l1, rx, $urandom_range(0, 3),
              (w == 1) ? 2'b10 : 2'b01, erd, $sformatf("rnd%0d", r), gw);
      m_last = w; m_rd = erd;
    end

    // Both requesters held from reset alternate 0,1,0.
    rst = 1'b1; tick(); rst = 1'b0; m_last = 1; m_rd = '0;
    run_txn(2'b11, 1'b1, 1'b0, 8'hA1, 8'hB2, 2'd1, 2'd2, 24'h5A6B00, 0, 2'b01, 24'h00005A,
            "rr0", gw);
    run_txn(2'b11, 1'b1, 1'b0, 8'hA1, 8'hB2, 2'd1, 2'd2, 24'h5A6B00, 1, 2'b10, 24'h005A6B,
            "rr1", gw);
    run_txn(2'b11, 1'b1, 1'b0, 8'hA1, 8'hB2, 2'd3, 2'd2, 24'h010203, 0, 2'b01, 24'h010203,
            "rr2", gw);
    req = 2'b00; m_last = 0; m_rd = 24'h010203;

    // Watchdog: engine silent after the opcode byte_start.
    eng_mute = 1'b1; opcode0 = 8'h03; rd_len0 = 2'd2; req = 2'b01;
    gw = -1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (gnt != 2'b00) begin gw = k; break; end
    end
    chk("timeout gnt seen", gw >= 0, 1);
    req = 2'b00;
    nbs = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (byte_start) begin nbs++; break; end
    end
    n = 0; seen_err = 1'b0; cs_at_err = 1'b0; bad_ev = 0;
    for (int k = 0; k < 400; k++) begin
      tick();
      n++;
      if (byte_start) nbs++;
      if (done != 2'b00) bad_ev++;
      if (err) begin seen_err = 1'b1; cs_at_err = chip_select; break; end
    end
    chk("timeout err seen", seen_err, 1);
    chk("timeout latency", n, To);
    chk("timeout cs high", cs_at_err, 1);
    chk("timeout byte_starts", nbs, 1);
    chk("timeout no done", bad_ev, 0);
    chk("timeout rd_data kept", rd_data, m_rd);
    for (int k = 0; k < 20 && busy; k++) tick();
    chk("timeout back to idle", busy, 0);
    eng_mute = 1'b0; m_last = 0;

    // Reset during WAIT_RX.
    opcode0 = 8'h0B; rd_len0 = 2'd3; eng_lat = 3; req = 2'b01;
    nbs = 0;
    for (int k = 0; k < 60 && nbs < 2; k++) begin
      tick();
      if (gnt != 2'b00) req = 2'b00;
      if (byte_start) nbs++;
    end
    chk("midreset reached rx byte", nbs, 2);
    tick();
    rst = 1'b1;
    #1;
    chk("midreset cs immediate", chip_select, 1);
    chk("midreset busy", busy, 0);
    bad_ev = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done != 2'b00 || err) bad_ev++;
    end
    rst = 1'b0; m_last = 1; m_rd = '0;
    chk("midreset no done/err", bad_ev, 0);
    run_txn(2'b01, 1'b0, 1'b0, 8'h9F, 8'h00, 2'd3, 2'd0, 24'h202015, 0, 2'b01, 24'h202015,
            "postreset", gw);
    chk("postreset grant latency", gw, 0);

    // Spurious byte_done while idle.
    bad_ev = 0;
    for (int k = 0; k < 6; k++) begin
      man_done = (k < 3);
      tick();
      if (busy || byte_start || !chip_select || gnt != 2'b00) bad_ev++;
    end
    man_done = 1'b0;
    chk("idle spurious byte_done", bad_ev, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_flash_sched.md
SPI_FLASH_SCHED -- requirements
Module: spi_flash_sched

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 2: minimum cycles chip_select stays high between transactions.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum cycles to wait for byte_done before aborting.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req  in  2  per-requester request level; held until gnt.
REQ-006 opcode0, opcode1  in  8 each  command byte of requester 0 / 1.
REQ-007 rd_len0, rd_len1  in  2 each  response bytes expected, 0..3.
REQ-008 gnt  out  2  one-hot, one-cycle pulse when a request is accepted.
REQ-009 done  out  2  one-hot, one-cycle pulse when the granted transaction ends normally.
REQ-010 err  out  1  one-cycle pulse when a transaction is aborted by timeout.
REQ-011 rd_data  out  24  response bytes, right-aligned.
REQ-012 busy  out  1  high from grant through the end of the gap.
REQ-013 chip_select  out  1  flash select, active-low.
REQ-014 byte_start  out  1  one-cycle pulse that starts one byte on the byte engine.
REQ-015 tx_byte  out  8  byte to shift out; valid while byte_start is high.
REQ-016 byte_done  in  1  one-cycle pulse from the byte engine: byte complete.
REQ-017 rx_byte  in  8  byte received; valid while byte_done is high.

Function
REQ-018 SHALL implement states IDLE, CS_SETUP, SEND_OP, WAIT_OP, SEND_RX, WAIT_RX, CS_HOLD, GAP.
REQ-019 IDLE, any req high at an edge: register gnt for the winner; latch its opcode and rd_len; clear the accumulator; drive chip_select low; go to CS_SETUP.
REQ-020 Arbitration SHALL be round-robin: if both req are high, grant the requester not granted last. The last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-021 CS_SETUP SHALL last exactly one cycle, then go to SEND_OP.
REQ-022 SEND_OP: pulse byte_start with tx_byte = latched opcode, then go to WAIT_OP.
REQ-023 WAIT_OP on byte_done: if rd_len = 0, go to CS_HOLD; else go to SEND_RX with remaining = rd_len.
REQ-024 SEND_RX: pulse byte_start with tx_byte = 8'h00, then go to WAIT_RX.
REQ-025 WAIT_RX on byte_done: acc <= {acc[15:0], rx_byte}; remaining decrements; if remaining becomes 0, go to CS_HOLD; else go to SEND_RX.
REQ-026 CS_HOLD (one cycle): chip_select high; rd_data <= acc (unused upper bytes zero); pulse done for the granted requester; go to GAP.
REQ-027 GAP SHALL hold GAP_CYCLES cycles, then go to IDLE. Requests SHALL NOT be granted in GAP.
REQ-028 busy SHALL be high in every state except IDLE.
REQ-029 byte_done outside WAIT_OP/WAIT_RX SHALL be ignored.
REQ-030 Deasserting req after gnt SHALL NOT affect the transaction in progress.
REQ-031 Opcode and length inputs SHALL be sampled only at grant; later changes are ignored.
REQ-032 Watchdog: counter cleared on every byte_start, increments in WAIT_OP/WAIT_RX. Reaching TIMEOUT: chip_select high, err pulse, no done, rd_data unchanged, go to GAP.
REQ-033 Never more than one byte_start outstanding; byte_start SHALL never be issued while chip_select is high.
REQ-034 rd_data SHALL hold its value until the next normal completion.

Reset
REQ-035 On rst, asynchronously and regardless of state:
- state = IDLE
- chip_select = 1
- gnt, done, err, byte_start, busy = 0
- tx_byte = 0, rd_data = 0
- counters cleared, last-grant pointer = 1
REQ-036 Reset mid-transaction SHALL abort without a done or err pulse.
REQ-037 The first grant SHALL be possible at the first edge after rst falls.

Verification
REQ-038 req=01, opcode0=9F, rd_len0=3, engine returns 20,20,15 -> gnt=01; tx sequence 9F,00,00,00; rd_data=202015; done=01; 4 byte_starts; chip_select low throughout.
REQ-039 req=11 held from reset -> grants in order 01,10,01; each transaction is separated by ≥ GAP_CYCLES with chip_select high.
REQ-040 opcode1=05, rd_len1=0 -> one byte_start (05); done=10; rd_data keeps its previous value.
REQ-041 rd_len0=2, engine never returns byte_done after the opcode -> err pulses 255 cycles after byte_start; chip_select=1; no done.
REQ-042 rst asserted during WAIT_RX -> chip_select=1 immediately; no done or err; next req=01 is granted normally.
REQ-043 Spurious byte_done in IDLE and GAP -> no state change; no extra byte_start.
